alu_sub8b_ser: RTL and testbench
================================

# alu_sub8b_ser

Bit-serial subtract-with-borrow unit for the 8085 ALU datapath. It computes minuend − subtrahend − borrow-in one bit per clock, LSB first, and exposes the full borrow chain so that borrow (CY) and half-borrow (AC) come from the same vector. It also returns sign, zero and parity flags. It is the inverse-direction companion of the 8-bit adder and is checked against it: (A − B − bi) + B + bi ≡ A mod 2^DATASIZE. It sits beside the adder for the SUB/SBB/CMP paths where area matters more than latency.

## Interface
- DATASIZE, 8, operand/result width; minimum 4 (the half-borrow needs bit 3).
- iCLK  in  1  clock, rising edge.
- iRSTn  in  1  reset, asynchronous, active-low.
- iStart  in  1  request strobe; sampled only in IDLE.
- iA  in  DATASIZE  minuend; latched on the accepting edge.
- iB  in  DATASIZE  subtrahend; latched on the accepting edge.
- iBrw  in  1  borrow-in; latched on the accepting edge.
- oD  out  DATASIZE  difference, registered.
- oB  out  DATASIZE  borrow chain: oB[k] is the borrow out of bit k; oB[DATASIZE-1] is the final borrow (CY); oB[3] is the half-borrow (AC).
- oS  out  1  sign, equal to oD[DATASIZE-1].
- oZ  out  1  1 when oD == 0.
- oP  out  1  1 when oD has an even number of ones (8085 parity sense).
- oBusy  out  1  1 while in SHIFT.
- oDone  out  1  one-cycle pulse marking that the results are valid.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE with iStart=1 at an edge:
  - latch iA, iB and iBrw into shift registers;
  - clear the bit counter;
  - move to SHIFT.
- IDLE with iStart=0: stay in IDLE.
- SHIFT, each edge:
  - one-bit full subtract: d = a ^ b ^ bi; bo = (~a & b) | (~a & bi) | (b & bi);
  - d and bo shift into the internal result and borrow registers; bo feeds the next bit's bi;
  - the counter increments.
- SHIFT, after the edge that processes bit DATASIZE-1:
  - oD, oB, oS, oZ and oP update together, all from the completed values;
  - move to DONE.
- DONE: lasts exactly one cycle, then IDLE. iStart is ignored in DONE.
- iStart during SHIFT or DONE is ignored and not queued.
- Results hold their value until the next completed operation. They do not change during SHIFT.
- Arithmetic: the result is modulo 2^DATASIZE. Borrow out is 1 exactly when A < B + bi as unsigned values. No signed-overflow output.

## Timing
- Reset (iRSTn low, asynchronous): state IDLE; oD, oB, oS, oZ, oP, oBusy and oDone all 0. Internal registers and counter are cleared.
- Reset mid-operation: the operation is abandoned and the previous results are cleared to 0. No oDone pulse.
- Latency: if start is accepted at edge t0, bits are processed at edges t1..tDATASIZE.
  - oBusy is high from t0 to tDATASIZE.
  - Results are valid and oDone=1 from tDATASIZE to tDATASIZE+1.
- Throughput: one operation per DATASIZE+2 cycles. The earliest next accept is at edge tDATASIZE+2, when iStart is high while in IDLE.
- oBusy and oDone are never high together.

## Structure
- Shared package holds the state encoding (IDLE/SHIFT/DONE), the default DATASIZE, and the counter-width constant clog2(DATASIZE).
- Sub-module alu_fsub1b: combinational one-bit full subtractor with ports a, b, bi, d, bo. It is instantiated once inside the serial loop.

## Test plan
- 8'h05 − 8'h03, iBrw=0 → oD=8'h02, oB[7]=0, oS=0, oZ=0, oP=0; oDone exactly 8 edges after the accepting edge.
- 8'h00 − 8'h01, iBrw=0 → oD=8'hFF, oB[7]=1, oB[3]=1, oS=1, oP=1.
- 8'h10 − 8'h01 → oD=8'h0F, oB[3]=1, oB[7]=0, oP=1.
- 8'h3C − 8'h3B, iBrw=1 → oD=8'h00, oZ=1, oP=1, oB[7]=0.
- Pulse iStart with new operands at cycles 3 and 9 after an accept → both ignored. Then drop iRSTn at cycle 5 of a fresh operation → all outputs 0 immediately, no oDone, and the next request completes normally.
- Exhaustive run over iBrw ∈ {0,1} and all iA, iB → {oB[7], oD} equals (iA − iB − iBrw) mod 2^(DATASIZE+1) with borrow as MSB; count errors and require ErrorCount=0.

Source files
------------

// File: rtl/alu_sub8b_ser_pkg.sv
// Shared types and constants for the bit-serial 8085 subtractor.
package alu_sub8b_ser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } sub_state_t;

  localparam int DATASIZE_DEF = 8;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CNT_W = cnt_w(DATASIZE_DEF);

endpackage

// File: rtl/alu_sub8b_ser_fsub1b.sv
// One-bit full subtractor: d = a - b - bi, bo is the borrow out.
module alu_fsub1b (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~a & bi) | (b & bi);

endmodule

// File: rtl/alu_sub8b_ser.sv
// Bit-serial subtract-with-borrow, LSB first, with full borrow chain
// and S/Z/P flags for the 8085 SUB/SBB/CMP paths.
module alu_sub8b_ser
  import alu_sub8b_ser_pkg::*;
#(
  parameter int DATASIZE = DATASIZE_DEF
) (
  input  logic                iCLK,
  input  logic                iRSTn,
  input  logic                iStart,
  input  logic [DATASIZE-1:0] iA,
  input  logic [DATASIZE-1:0] iB,
  input  logic                iBrw,
  output logic [DATASIZE-1:0] oD,
  output logic [DATASIZE-1:0] oB,
  output logic                oS,
  output logic                oZ,
  output logic                oP,
  output logic                oBusy,
  output logic                oDone
);

  localparam int CW = cnt_w(DATASIZE);
  localparam logic [CW-1:0] LAST = CW'(DATASIZE - 1);

  sub_state_t r_state, w_next;

  logic [DATASIZE-1:0] r_a, r_b, r_dsh, r_bsh;
  logic [DATASIZE-1:0] r_od, r_ob;
  logic                r_bi, r_os, r_oz, r_op;
  logic [CW-1:0]       r_cnt;

  logic                w_d, w_bo, w_last;
  logic [DATASIZE-1:0] w_dn, w_bn;

  alu_fsub1b u_fsub (
    .a  (r_a[0]),
    .b  (r_b[0]),
    .bi (r_bi),
    .d  (w_d),
    .bo (w_bo)
  );

  // Results enter at the MSB so bit 0 lands in place after DATASIZE shifts
  assign w_dn   = {w_d,  r_dsh[DATASIZE-1:1]};
  assign w_bn   = {w_bo, r_bsh[DATASIZE-1:1]};
  assign w_last = (r_cnt == LAST);

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (iStart) w_next = ST_SHIFT;
      ST_SHIFT: if (w_last) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      r_a   <= '0;
      r_b   <= '0;
      r_bi  <= 1'b0;
      r_dsh <= '0;
      r_bsh <= '0;
      r_cnt <= '0;
      r_od  <= '0;
      r_ob  <= '0;
      r_os  <= 1'b0;
      r_oz  <= 1'b0;
      r_op  <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (iStart) begin
            r_a   <= iA;
            r_b   <= iB;
            r_bi  <= iBrw;
            r_cnt <= '0;
          end
        end
        ST_SHIFT: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_bi  <= w_bo;
          r_dsh <= w_dn;
          r_bsh <= w_bn;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_od <= w_dn;
            r_ob <= w_bn;
            r_os <= w_dn[DATASIZE-1];
            r_oz <= ~|w_dn;
            r_op <= ~^w_dn;
          end
        end
        default: ;
      endcase
    end
  end

  assign oD    = r_od;
  assign oB    = r_ob;
  assign oS    = r_os;
  assign oZ    = r_oz;
  assign oP    = r_op;
  assign oBusy = (r_state == ST_SHIFT);
  assign oDone = (r_state == ST_DONE);

endmodule

// File: tb/tb_alu_sub8b_ser.sv
// Scoreboard bench for alu_sub8b_ser: random and directed subtractions
// checked against an arithmetic model, plus ignore/abort handling.
module tb_alu_sub8b_ser;

  localparam int DW = 8;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [DW-1:0] b;
    logic          s;
    logic          z;
    logic          p;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] a_in = '0;
  logic [DW-1:0] b_in = '0;
  logic          brw = 1'b0;
  logic [DW-1:0] o_d, o_b;
  logic          o_s, o_z, o_p, o_busy, o_done;

  int   ncmp = 0;
  int   nerr = 0;
  exp_t q[$];

  alu_sub8b_ser #(.DATASIZE(DW)) dut (
    .iCLK   (clk),
    .iRSTn  (rst_n),
    .iStart (start),
    .iA     (a_in),
    .iB     (b_in),
    .iBrw   (brw),
    .oD     (o_d),
    .oB     (o_b),
    .oS     (o_s),
    .oZ     (o_z),
    .oP     (o_p),
    .oBusy  (o_busy),
    .oDone  (o_done)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [DW-1:0] a,
                                 input logic [DW-1:0] b,
                                 input logic bi);
    exp_t e;
    int   diff, m;
    diff = int'(a) - int'(b) - int'(bi);
    e.d = DW'(diff);
    for (int k = 0; k < DW; k++) begin
      m = (1 << (k + 1)) - 1;
      e.b[k] = ((int'(a) & m) < ((int'(b) & m) + int'(bi)));
    end
    e.s = e.d[DW-1];
    e.z = (e.d == 0);
    e.p = ($countones(e.d) % 2 == 0);
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    ncmp++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Monitor: every oDone pulse must match the oldest expected result
  always @(negedge clk) begin
    if (rst_n && o_done) begin
      if (q.size() == 0) begin
        ncmp++;
        nerr++;
        $display("FAIL unexpected_done actual=1 required=0");
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("result", {o_d, o_b, o_s, o_z, o_p}, {e.d, e.b, e.s, e.z, e.p});
        chk("busy_with_done", o_busy, 0);
      end
    end
  end

  // mode 0: normal, 1: stray iStart at t3 and t9, 2: reset after t5
  task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic bi, input int mode);
    int lim;
    lim = (mode == 1) ? DW + 2 : DW + 1;
    @(negedge clk);
    a_in = a; b_in = b; brw = bi; start = 1'b1;
    if (mode != 2) q.push_back(model(a, b, bi));
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_t0", o_busy, 1);
    for (int c = 1; c <= lim; c++) begin
      @(negedge clk);
      if (mode == 1 && (c == 3 || c == 9)) begin
        start = 1'b1;
        a_in = DW'($urandom);
        b_in = DW'($urandom);
        brw = 1'($urandom);
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (mode == 2 && c == 5) begin
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", {o_d, o_b, o_s, o_z, o_p, o_busy, o_done}, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (DW + 4) @(posedge clk);
        return;
      end
      if (c < DW)       chk("busy_shift", {o_busy, o_done}, 2'b10);
      else if (c == DW) chk("done_t8", {o_busy, o_done}, 2'b01);
      else              chk("idle_after", {o_busy, o_done}, 2'b00);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {o_d, o_b, o_s, o_z, o_p, o_busy, o_done}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(8'h05, 8'h03, 1'b0, 0);
    run_op(8'h00, 8'h01, 1'b0, 0);
    run_op(8'h10, 8'h01, 1'b0, 0);
    run_op(8'h3C, 8'h3B, 1'b1, 0);
    run_op(8'h00, 8'h00, 1'b1, 0);
    run_op(8'hFF, 8'hFF, 1'b1, 0);
    run_op(8'h80, 8'h7F, 1'b0, 1);
    run_op(8'h55, 8'hAA, 1'b1, 2);
    chk("after_abort_queue", q.size(), 0);
    run_op(8'hA5, 8'h5A, 1'b0, 0);

    for (int i = 0; i < 400; i++)
      run_op(DW'($urandom), DW'($urandom), 1'($urandom), 0);

    repeat (3) @(posedge clk);
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
